// File: rtl/mul_iter_unit.sv
// mul_iter_unit
// Multi-cycle RV32M multiply unit (MUL, MULH, MULHSU, MULHU) that sits between
// the register file read ports and its write port. Operands are converted to
// magnitudes, multiplied with a radix-2 shift-add loop (one bit per cycle), and
// the sign is restored in a single fix-up cycle before a one-cycle writeback.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request, sampled only while idle
//   flush    synchronous abort, beats everything except reset
//   op       00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
//   rs1_val  multiplicand (rv1)
//   rs2_val  multiplier (rv2)
//   rd_in    destination register index
//   busy     high while iterating or fixing up the sign
//   done     one-cycle pulse, result valid
//   wb_we    register-file write enable (same as done)
//   wb_rd    latched destination index
//   wb_data  result
module mul_iter_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             flush,
  input  logic [1:0]       op,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [4:0]       rd_in,
  output logic             busy,
  output logic             done,
  output logic             wb_we,
  output logic [4:0]       wb_rd,
  output logic [XLEN-1:0]  wb_data
);

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [1:0]        op_q;
  logic [4:0]        rd_q;
  logic              neg_q;
  logic [CNT_W-1:0]  count;
  logic [XLEN-1:0]   mplier;
  logic [2*XLEN-1:0] mcand;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] product;

  logic              s1;
  logic              s2;
  logic [XLEN-1:0]   mag1;
  logic [XLEN-1:0]   mag2;

  // Sign handling at acceptance: only signed operands contribute a sign flag,
  // and each operand is replaced by its magnitude. The magnitude of the most
  // negative value wraps to itself, which is still correct read as unsigned.
  assign s1   = ((op == OP_MULH) || (op == OP_MULHSU)) && rs1_val[XLEN-1];
  assign s2   = (op == OP_MULH) && rs2_val[XLEN-1];
  assign mag1 = s1 ? -rs1_val : rs1_val;
  assign mag2 = s2 ? -rs2_val : rs2_val;

  assign product = neg_q ? -acc : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    wb_we      = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE: if (start) state_next = CALC;
        CALC: if (count == LAST_ITER) state_next = FIX;
        FIX:  state_next = DONE;
        DONE: state_next = IDLE;
        default: state_next = IDLE;
      endcase
    end
    case (state)
      CALC, FIX: busy = 1'b1;
      DONE: begin
        done  = 1'b1;
        wb_we = 1'b1;
      end
      default: ;
    endcase
  end

  // The multiplicand is kept pre-shifted in a 2*XLEN register, so after k
  // iterations it already equals the original magnitude shifted left by k.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      count   <= '0;
      mplier  <= '0;
      mcand   <= '0;
      acc     <= '0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            rd_q   <= rd_in;
            neg_q  <= s1 ^ s2;
            count  <= '0;
            mplier <= mag2;
            mcand  <= {{XLEN{1'b0}}, mag1};
            acc    <= '0;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CNT_W'(1);
        end
        FIX: begin
          wb_data <= (op_q == OP_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
          wb_rd   <= rd_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_iter_unit.sv
// tb_mul_iter_unit
// Scoreboard bench for mul_iter_unit. Every accepted request pushes its
// expected result, destination and completion cycle; an independent monitor
// pops and compares whenever done is presented.
module tb_mul_iter_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic [1:0]  op;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   cyc;
  int   checks;
  int   errors;
  int   dones_seen;
  int   accepted;

  logic [31:0] special [4];

  mul_iter_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .flush   (flush),
    .op      (op),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .rd_in   (rd_in),
    .busy    (busy),
    .done    (done),
    .wb_we   (wb_we),
    .wb_rd   (wb_rd),
    .wb_data (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: sign- or zero-extend each operand to 64 bits as the opcode
  // dictates, multiply, and pick the low or high word.
  function automatic logic [31:0] refModel(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    logic [63:0] p;
    ea = {{32{((o == 2'b01) || (o == 2'b10)) && a[31]}}, a};
    eb = {{32{(o == 2'b01) && b[31]}}, b};
    p  = ea * eb;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, actual, expected, cyc);
    end
  endtask

  // Called at a negedge while the unit is idle; the request is accepted on the
  // following posedge and done is expected 33 edges after that.
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] rd);
    exp_t e;
    start   = 1'b1;
    flush   = 1'b0;
    op      = o;
    rs1_val = a;
    rs2_val = b;
    rd_in   = rd;
    e.data  = refModel(o, a, b);
    e.rd    = rd;
    e.due   = cyc + 1 + 33;
    sb.push_back(e);
    accepted++;
    @(negedge clk);
    start   = 1'b0;
    op      = 2'($urandom);
    rs1_val = $urandom;
    rs2_val = $urandom;
    rd_in   = 5'($urandom);
  endtask

  // Wait (bounded) until every queued result has been seen, then one more
  // negedge so the unit is back in IDLE.
  task automatic waitDrain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (wb_we && !done) begin
      checks++;
      errors++;
      $display("[TB] FAIL wb_we_without_done: got wb_we=1 expected 0 at cycle %0d", cyc);
    end
    if (done) begin
      dones_seen++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_done: got done=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("wb_data", wb_data, e.data);
        checkOutput("wb_rd", 32'(wb_rd), 32'(e.rd));
        checkOutput("wb_we", 32'(wb_we), 32'd1);
        checkOutput("latency", 32'(cyc), 32'(e.due));
      end
    end
  end

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;

    special[0] = 32'h0000_0000;
    special[1] = 32'h8000_0000;
    special[2] = 32'hFFFF_FFFF;
    special[3] = 32'h0000_0001;

    cyc        = 0;
    checks     = 0;
    errors     = 0;
    dones_seen = 0;
    accepted   = 0;
    rst_n      = 1'b0;
    start      = 1'b0;
    flush      = 1'b0;
    op         = 2'b00;
    rs1_val    = '0;
    rs2_val    = '0;
    rd_in      = '0;

    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_wb_data", wb_data, 32'd0);
    checkOutput("reset_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // MUL 7 * -7
    applyStimulus(2'b00, 32'd7, 32'hFFFF_FFF9, 5'd5);
    checkOutput("busy_after_start", 32'(busy), 32'd1);
    waitDrain();

    // MULH of the most negative value with itself, then MULHU right after
    applyStimulus(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd7);
    waitDrain();
    applyStimulus(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8);
    waitDrain();

    // MULHSU and MUL on all-ones operands
    applyStimulus(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    waitDrain();
    applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    waitDrain();

    // Extra start pulses while busy must be ignored
    applyStimulus(2'b00, 32'd1234, 32'd5678, 5'd12);
    repeat (3) @(negedge clk);
    start = 1'b1; op = 2'b11; rs1_val = 32'hDEAD_BEEF; rs2_val = 32'h1111_2222; rd_in = 5'd30;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1; op = 2'b01; rs1_val = 32'h7777_0000; rs2_val = 32'h0000_9999; rd_in = 5'd31;
    @(negedge clk);
    start = 1'b0;
    waitDrain();

    // Flush on the tenth iteration edge: no writeback, unit idle afterwards
    applyStimulus(2'b00, 32'hABCD_0123, 32'h0000_0F0F, 5'd17);
    void'(sb.pop_back());
    accepted--;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("busy_after_flush", 32'(busy), 32'd1 - 32'd1);
    repeat (40) @(negedge clk);
    applyStimulus(2'b00, 32'd3, 32'd4, 5'd3);
    waitDrain();

    // Flush together with start in IDLE: not accepted
    start = 1'b1; flush = 1'b1; op = 2'b00; rs1_val = 32'd9; rs2_val = 32'd9; rd_in = 5'd4;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("busy_start_with_flush", 32'(busy), 32'd0);
    repeat (36) @(negedge clk);

    // Randomized operations with some boundary operands mixed in
    for (int n = 0; n < 20; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? special[$urandom_range(0, 3)] : $urandom;
      applyStimulus(ro, ra, rb, 5'($urandom));
      waitDrain();
    end

    // Asynchronous reset in the middle of an operation
    applyStimulus(2'b01, 32'h1234_5678, 32'h8765_4321, 5'd21);
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    accepted--;
    checkOutput("async_rst_busy", 32'(busy), 32'd0);
    checkOutput("async_rst_done", 32'(done), 32'd0);
    checkOutput("async_rst_wb_we", 32'(wb_we), 32'd0);
    checkOutput("async_rst_wb_data", wb_data, 32'd0);
    checkOutput("async_rst_wb_rd", 32'(wb_rd), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("busy_after_reset_release", 32'(busy), 32'd0);

    checkOutput("done_count", 32'(dones_seen), 32'(accepted));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
